// File: rtl/cpu_types_pkg.sv
// Purpose : shared types and constants for the MEM-stage controller.
// Latency : n/a (types only).
// Backpressure: n/a.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } mem_state_t;

  // Value written back to rt by a store-conditional that succeeded.
  localparam word_t SC_SUCCESS = 32'h1;

endpackage

// File: rtl/mem_stage_if.sv
// Purpose : data-cache request/response bus between mem_stage and the cache.
// Latency : n/a (wires only).
// Backpressure: requests are held by the master until the slave raises dhit.
// Ports   : master drives dmemREN/dmemWEN/dmemaddr/dmemstore and receives
//           dhit/dmemload; slave is the mirror image.
interface mem_stage_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              dmemREN;
  logic              dmemWEN;
  logic [ADDR_W-1:0] dmemaddr;
  logic [DATA_W-1:0] dmemstore;
  logic              dhit;
  logic [DATA_W-1:0] dmemload;

  modport master (
    output dmemREN, dmemWEN, dmemaddr, dmemstore,
    input  dhit, dmemload
  );

  modport slave (
    input  dmemREN, dmemWEN, dmemaddr, dmemstore,
    output dhit, dmemload
  );
endinterface

// File: rtl/mem_stage_link_reg.sv
// Purpose : LL/SC link register; tracks one linked word and judges SC success.
// Latency : sc_ok is combinational; link state updates on the next CLK edge.
// Backpressure: none; events are sampled every cycle.
// Ports   : ll_done/st_done/sc_done are completion pulses from the MEM FSM,
//           addr is the current effective address, linkinval/snoopaddr come
//           from coherence; link_valid/link_addr/sc_ok are outputs.
module mem_stage_link_reg #(
  parameter int ADDR_W = 32
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              ll_done,
  input  logic              st_done,
  input  logic              sc_done,
  input  logic [ADDR_W-1:0] addr,
  input  logic              linkinval,
  input  logic [ADDR_W-1:0] snoopaddr,
  output logic              link_valid,
  output logic [ADDR_W-1:0] link_addr,
  output logic              sc_ok
);

  logic              link_valid_q, link_valid_d;
  logic [ADDR_W-1:0] link_addr_q, link_addr_d;

  // Byte offset bits never participate in a compare.
  function automatic logic same_word(input logic [ADDR_W-1:0] a,
                                     input logic [ADDR_W-1:0] b);
    return (a >> 2) == (b >> 2);
  endfunction

  always_comb begin
    sc_ok = link_valid_q && same_word(link_addr_q, addr) &&
            !(linkinval && same_word(snoopaddr, addr));
  end

  always_comb begin
    link_valid_d = link_valid_q;
    link_addr_d  = link_addr_q;
    if (ll_done) begin
      link_valid_d = 1'b1;
      link_addr_d  = addr;
    end
    if (st_done && same_word(addr, link_addr_q)) link_valid_d = 1'b0;
    if (sc_done) link_valid_d = 1'b0;
    // Compared against the post-update address so an invalidate that lands
    // on the same cycle as the LL completion still kills the new link.
    if (linkinval && same_word(snoopaddr, link_addr_d)) link_valid_d = 1'b0;
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      link_valid_q <= 1'b0;
      link_addr_q  <= '0;
    end else begin
      link_valid_q <= link_valid_d;
      link_addr_q  <= link_addr_d;
    end
  end

  assign link_valid = link_valid_q;
  assign link_addr  = link_addr_q;

endmodule

// File: rtl/mem_stage.sv
// Purpose : MEM-stage controller: issues data-cache requests, runs LL/SC,
//           presents load/SC result to the MEM/WB latch.
// Latency : request asserts in the same cycle the op arrives; result is
//           visible combinationally on the dhit cycle and held until advance.
// Backpressure: mem_stall holds the upstream pipe while a request awaits dhit.
// Ports   : EX/MEM controls (valid, MemRead, MemWrite, is_ll, is_sc, ALUOut,
//           storedata), advance/flush from hazard logic, linkinval/snoopaddr
//           from coherence, dbus to the cache, memload_out and mem_stall out.
module mem_stage
  import cpu_types_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              valid,
  input  logic              MemRead,
  input  logic              MemWrite,
  input  logic              is_ll,
  input  logic              is_sc,
  input  logic [ADDR_W-1:0] ALUOut,
  input  logic [DATA_W-1:0] storedata,
  input  logic              advance,
  input  logic              flush,
  input  logic              linkinval,
  input  logic [ADDR_W-1:0] snoopaddr,
  mem_stage_if.master       dbus,
  output logic [DATA_W-1:0] memload_out,
  output logic              mem_stall
);

  mem_state_t        state_q, state_d;
  logic [DATA_W-1:0] load_q, load_d;
  logic              mem_op;
  logic              issue;
  logic              done;
  logic              sc_fail;
  logic              sc_ok;
  logic              link_valid;
  logic [ADDR_W-1:0] link_addr;
  logic [DATA_W-1:0] result;

  assign mem_op = valid && (MemRead || MemWrite);
  assign result = is_sc ? DATA_W'(SC_SUCCESS) : dbus.dmemload;

  always_comb begin
    state_d        = state_q;
    load_d         = load_q;
    issue          = 1'b0;
    done           = 1'b0;
    sc_fail        = 1'b0;
    dbus.dmemREN   = 1'b0;
    dbus.dmemWEN   = 1'b0;
    dbus.dmemaddr  = '0;
    dbus.dmemstore = '0;
    memload_out    = '0;
    mem_stall      = 1'b0;

    case (state_q)
      IDLE: begin
        if (mem_op && !flush) begin
          // A doomed SC never touches the cache; it retires with result 0.
          if (is_sc && !sc_ok) begin
            sc_fail = 1'b1;
            load_d  = '0;
            state_d = DONE;
          end else begin
            issue = 1'b1;
          end
        end
      end
      REQ: begin
        if (flush) state_d = IDLE;
        else       issue   = 1'b1;
      end
      DONE: begin
        memload_out = load_q;
        if (flush || advance) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // The first request cycle happens in IDLE, so IDLE and REQ share this.
    if (issue) begin
      dbus.dmemREN   = MemRead;
      dbus.dmemWEN   = MemWrite;
      dbus.dmemaddr  = ALUOut;
      dbus.dmemstore = storedata;
      mem_stall      = !dbus.dhit;
      if (dbus.dhit) begin
        done        = 1'b1;
        load_d      = result;
        memload_out = result;
        state_d     = DONE;
      end else begin
        state_d     = REQ;
      end
    end

    // Reset must drop the request at once, not at the next edge.
    if (!nRST) begin
      dbus.dmemREN   = 1'b0;
      dbus.dmemWEN   = 1'b0;
      dbus.dmemaddr  = '0;
      dbus.dmemstore = '0;
      memload_out    = '0;
      mem_stall      = 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= IDLE;
      load_q  <= '0;
    end else begin
      state_q <= state_d;
      load_q  <= load_d;
    end
  end

  mem_stage_link_reg #(.ADDR_W(ADDR_W)) u_link (
    .CLK        (CLK),
    .nRST       (nRST),
    .ll_done    (done && is_ll),
    .st_done    (done && MemWrite),
    .sc_done    ((done && is_sc) || sc_fail),
    .addr       (ALUOut),
    .linkinval  (linkinval),
    .snoopaddr  (snoopaddr),
    .link_valid (link_valid),
    .link_addr  (link_addr),
    .sc_ok      (sc_ok)
  );

endmodule

// File: tb/tb_mem_stage.sv
module tb_mem_stage;
  import cpu_types_pkg::*;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        valid, MemRead, MemWrite, is_ll, is_sc;
  logic [31:0] ALUOut, storedata, snoopaddr;
  logic        advance, flush, linkinval;
  logic [31:0] memload_out;
  logic        mem_stall;
  int          checks = 0;
  int          errors = 0;

  always #5 CLK = ~CLK;

  mem_stage_if dbus ();

  mem_stage dut (
    .CLK         (CLK),
    .nRST        (nRST),
    .valid       (valid),
    .MemRead     (MemRead),
    .MemWrite    (MemWrite),
    .is_ll       (is_ll),
    .is_sc       (is_sc),
    .ALUOut      (ALUOut),
    .storedata   (storedata),
    .advance     (advance),
    .flush       (flush),
    .linkinval   (linkinval),
    .snoopaddr   (snoopaddr),
    .dbus        (dbus),
    .memload_out (memload_out),
    .mem_stall   (mem_stall)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic clr();
    valid = 0; MemRead = 0; MemWrite = 0; is_ll = 0; is_sc = 0;
    advance = 0; flush = 0; linkinval = 0; dbus.dhit = 0;
  endtask

  task automatic set_op(input logic r, input logic w, input logic ll, input logic sc,
                        input logic [31:0] a, input logic [31:0] d);
    valid = 1; MemRead = r; MemWrite = w; is_ll = ll; is_sc = sc;
    ALUOut = a; storedata = d;
  endtask

  // From DONE: pulse advance for one edge, then drop the instruction.
  task automatic retire();
    dbus.dhit = 0;
    advance = 1;
    tick();
    clr();
  endtask

  task automatic ll_quick(input logic [31:0] a);
    set_op(1, 0, 1, 0, a, 0);
    dbus.dhit = 1; dbus.dmemload = 32'h0BAD0BAD;
    tick();
    retire();
  endtask

  initial begin
    nRST = 0; clr(); ALUOut = 0; storedata = 0; snoopaddr = 0; dbus.dmemload = 0;
    #1;
    chk("rst_ren", dbus.dmemREN, 0);
    chk("rst_wen", dbus.dmemWEN, 0);
    chk("rst_addr", dbus.dmemaddr, 0);
    chk("rst_memload", memload_out, 0);
    chk("rst_stall", mem_stall, 0);
    chk("rst_state", dut.state_q, IDLE);
    chk("rst_link", dut.u_link.link_valid_q, 0);
    chk("rst_load_q", dut.load_q, 0);
    tick(); tick();
    nRST = 1;
    tick();

    // 1: LW 0x100, three waiting cycles then dhit
    set_op(1, 0, 0, 0, 32'h100, 0);
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("lw_ren_wait", dbus.dmemREN, 1);
      chk("lw_stall_wait", mem_stall, 1);
      chk("lw_addr", dbus.dmemaddr, 32'h100);
      tick();
    end
    dbus.dhit = 1; dbus.dmemload = 32'hDEADBEEF;
    #1;
    chk("lw_hit_data", memload_out, 32'hDEADBEEF);
    chk("lw_hit_stall", mem_stall, 0);
    tick();
    dbus.dhit = 0; dbus.dmemload = 0;
    #1;
    chk("lw_done_state", dut.state_q, DONE);
    chk("lw_done_data", memload_out, 32'hDEADBEEF);
    chk("lw_done_ren", dbus.dmemREN, 0);
    tick();
    chk("lw_hold_state", dut.state_q, DONE);
    chk("lw_hold_ren", dbus.dmemREN, 0);
    advance = 1;
    #1;
    chk("lw_adv_no_same_cycle", dbus.dmemREN, 0);
    tick();
    advance = 0;
    chk("lw_next_issue", dbus.dmemREN, 1);
    clr();
    #1;
    chk("nonmem_ren", dbus.dmemREN, 0);
    chk("nonmem_memload", memload_out, 0);

    // 2: SW 0x12345678 to 0x200
    set_op(0, 1, 0, 0, 32'h200, 32'h12345678);
    #1;
    chk("sw_wen", dbus.dmemWEN, 1);
    chk("sw_ren", dbus.dmemREN, 0);
    chk("sw_addr", dbus.dmemaddr, 32'h200);
    chk("sw_store", dbus.dmemstore, 32'h12345678);
    chk("sw_stall", mem_stall, 1);
    tick();
    chk("sw_req_state", dut.state_q, REQ);
    chk("sw_req_wen", dbus.dmemWEN, 1);
    dbus.dhit = 1;
    #1;
    chk("sw_hit_stall", mem_stall, 0);
    tick();
    chk("sw_done_state", dut.state_q, DONE);
    retire();

    // 3: LL 0x300 then SC 0x300 succeeds
    ll_quick(32'h300);
    chk("ll_link_set", dut.u_link.link_valid_q, 1);
    set_op(0, 1, 0, 1, 32'h300, 32'h77);
    #1;
    chk("sc_ok_wen", dbus.dmemWEN, 1);
    chk("sc_ok_stall", mem_stall, 1);
    dbus.dhit = 1;
    #1;
    chk("sc_ok_hit_result", memload_out, 1);
    tick();
    dbus.dhit = 0;
    #1;
    chk("sc_ok_done_result", memload_out, 1);
    chk("sc_ok_link_clear", dut.u_link.link_valid_q, 0);
    retire();

    // 4: LL, snoop invalidate, SC fails without touching the cache
    ll_quick(32'h300);
    linkinval = 1; snoopaddr = 32'h300;
    tick();
    linkinval = 0;
    chk("inval_link_clear", dut.u_link.link_valid_q, 0);
    set_op(0, 1, 0, 1, 32'h300, 32'h77);
    #1;
    chk("sc_inval_wen", dbus.dmemWEN, 0);
    chk("sc_inval_stall", mem_stall, 0);
    chk("sc_inval_result", memload_out, 0);
    tick();
    chk("sc_inval_state", dut.state_q, DONE);
    chk("sc_inval_done_result", memload_out, 0);
    chk("sc_inval_stall_done", mem_stall, 0);
    retire();

    // 5a: LL, SW to the linked word, SC fails
    ll_quick(32'h300);
    set_op(0, 1, 0, 0, 32'h300, 32'h5);
    dbus.dhit = 1;
    tick();
    retire();
    chk("sw_same_link_clear", dut.u_link.link_valid_q, 0);
    set_op(0, 1, 0, 1, 32'h300, 32'h77);
    #1;
    chk("sc_after_sw_wen", dbus.dmemWEN, 0);
    tick();
    chk("sc_after_sw_result", memload_out, 0);
    retire();

    // 5b: LL, SW to a different word, SC succeeds
    ll_quick(32'h300);
    set_op(0, 1, 0, 0, 32'h304, 32'h5);
    dbus.dhit = 1;
    tick();
    retire();
    chk("sw_other_link_kept", dut.u_link.link_valid_q, 1);
    set_op(0, 1, 0, 1, 32'h300, 32'h77);
    #1;
    chk("sc_after_sw304_wen", dbus.dmemWEN, 1);
    dbus.dhit = 1;
    #1;
    chk("sc_after_sw304_result", memload_out, 1);
    tick();
    retire();

    // 5c: byte offset ignored: LL 0x300, SC 0x303 succeeds
    ll_quick(32'h300);
    set_op(0, 1, 0, 1, 32'h303, 32'h77);
    #1;
    chk("sc_offset_wen", dbus.dmemWEN, 1);
    dbus.dhit = 1;
    tick();
    retire();

    // 6a: flush during REQ of an LL with dhit on the same cycle
    set_op(1, 0, 1, 0, 32'h300, 0);
    tick();
    chk("flush_pre_state", dut.state_q, REQ);
    flush = 1; dbus.dhit = 1; dbus.dmemload = 32'h55555555;
    #1;
    chk("flush_ren_drop", dbus.dmemREN, 0);
    chk("flush_stall", mem_stall, 0);
    tick();
    clr();
    chk("flush_state", dut.state_q, IDLE);
    chk("flush_load_q", dut.load_q, 1);
    chk("flush_no_link", dut.u_link.link_valid_q, 0);

    // 6b: reset asserted during REQ
    ll_quick(32'h300);
    chk("pre_rst_link", dut.u_link.link_valid_q, 1);
    set_op(1, 0, 0, 0, 32'h100, 0);
    tick();
    chk("pre_rst_ren", dbus.dmemREN, 1);
    nRST = 0;
    #1;
    chk("mid_rst_ren", dbus.dmemREN, 0);
    chk("mid_rst_stall", mem_stall, 0);
    chk("mid_rst_state", dut.state_q, IDLE);
    chk("mid_rst_link", dut.u_link.link_valid_q, 0);
    tick();
    clr();
    nRST = 1;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
